mul_sched: RTL
==============

// Module: mul_sched
// PURPOSE
//  Issue controller for the shared 4-cycle, non-pipelined 32x32 multiplier (mul32), implementing RV32M MUL/MULH/MULHSU/MULHU.
//  Sits between the M-extension reservation station and the CDB.
//  Buffers requests with their ROB tags, sequences one multiply at a time, and selects the hi or lo product word.
//  Broadcasts the result with valid/ready and discards in-flight work on pipeline flush.
// PARAMETERS
//  DEPTH  4  request FIFO entries; power of two, >=2
//  TAG_W  5  ROB tag width
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  flush         in   1      mispredict/exception flush
//  req_valid     in   1      request offered
//  req_ready     out  1      FIFO not full
//  req_op        in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  req_rs1       in   32     operand a
//  req_rs2       in   32     operand b
//  req_tag       in   TAG_W  destination ROB tag
//  mul_in_en     out  1      start pulse to mul32
//  mul_a, mul_b  out  32     operands to mul32
//  mul_a_signed  out  1      a signed
//  mul_b_signed  out  1      b signed
//  mul_idle      in   1      mul32 idle
//  mul_out_en    in   1      mul32 one-cycle done pulse
//  mul_hi        in   32     mul32 sum_hi
//  mul_lo        in   32     mul32 sum_lo
//  cdb_valid     out  1      result valid
//  cdb_ready     in   1      CDB grant
//  cdb_tag       out  TAG_W  result ROB tag
//  cdb_data      out  32     result word
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, FSM=S_IDLE, killed=0, cdb_valid=0, cdb_tag/cdb_data=0, mul_in_en=0; req_ready=1 after release.
//  Enqueue: on req_valid&&req_ready; push {op,rs1,rs2,tag}. No bypass: an entry is dispatchable the cycle after the push.
//  Signedness: MUL/MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned. MUL selects lo; others select hi.
//  mul_a/mul_b/signed flags are driven combinationally from the FIFO head; they are meaningful only when mul_in_en=1.
//  FSM S_IDLE: dispatch when FIFO non-empty && mul_idle && (!cdb_valid || cdb_ready) && !flush.
//    On dispatch: mul_in_en=1 for exactly one cycle; pop the head; latch head op/tag into in-flight regs; go to S_WAIT.
//  FSM S_WAIT: mul_in_en=0 (mul32 idle lags one cycle, so the controller never re-pulses).
//    On mul_out_en: if killed, drop the result and clear killed.
//    Otherwise load the result reg with {tag, hi|lo}; cdb_valid=1 next cycle. Go to S_IDLE in both cases.
//  Latency: 4 cycles from mul_in_en to mul_out_en. Issue-to-cdb_valid is 6 cycles with an empty pipe (push, dispatch, 4, capture).
//  Result reg: holds value stable while cdb_valid&&!cdb_ready; clears on handshake.
//    The dispatch rule guarantees it is free when mul_out_en arrives.
//  Throughput: 1 result per 5 cycles sustained.
//  Flush: next edge clears FIFO and cdb_valid.
//    If S_WAIT, sets killed; the multiply completes and is discarded. mul32 is never reset by this block.
//    req accepted in the flush cycle is dropped.
//    flush && mul_out_en same cycle: result dropped, killed stays 0.
//  Full/empty: req_ready=0 when DEPTH entries are held. Push and pop in the same cycle when full is not allowed (req_ready already 0).
//    Push and pop when 1 entry is held is legal. Pointers wrap modulo DEPTH with an extra wrap bit.
//  Reset mid-operation: all state cleared; mul32 must be reset by the same system reset.
// STRUCTURE
//  mul_pkg: localparams OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU; FSM encodings S_IDLE/S_WAIT.
//  Sub-module mul_req_fifo (DEPTH x (2+32+32+TAG_W), async-reset pointers).
//  mul32 is instantiated beside this block by the EX-stage top.
// TESTING
//  MUL 7*6, tag 3 -> mul_in_en pulse 1 cycle after push; cdb_valid with tag=3, data=42.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
//  MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MUL 0x80000000*0x80000000 -> 0x00000000.
//  Push 5 back-to-back with cdb_ready=0 -> req_ready low after 4 queued + 1 in flight.
//    Only 1 result held; no second mul_in_en until grant; order of tags preserved.
//  flush 2 cycles after dispatch with 2 queued -> no cdb_valid for any of them; next request completes correctly.
//  Assert rst_n low during S_WAIT with cdb_valid=1 -> all outputs 0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the M-extension multiply issue controller.
// Opcode encodings, FSM state encodings and operand-signedness helpers.
package mul_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   function automatic logic op_a_signed(input logic [1:0] op);
      return op != OP_MULHU;
   endfunction

   function automatic logic op_b_signed(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/mul_req_fifo.sv
// Request FIFO for the multiply issue controller.
// Pointers carry an extra wrap bit so full and empty are distinguishable; clr empties it.
module mul_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 71
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: nothing is read unless the pointers say it is valid.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mul_sched.sv
// Issue controller for the shared 4-cycle non-pipelined mul32: queues tagged requests,
// runs one multiply at a time and broadcasts the hi/lo word on the CDB.
//
//   state  | meaning
//   S_IDLE | no multiply in flight; dispatch the FIFO head when mul32 and result reg are free
//   S_WAIT | multiply in flight; wait for mul_out_en, drop the result if a flush killed it
module mul_sched
   import mul_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             mul_in_en,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   output logic             mul_a_signed,
   output logic             mul_b_signed,
   input  logic             mul_idle,
   input  logic             mul_out_en,
   input  logic [31:0]      mul_hi,
   input  logic [31:0]      mul_lo,
   output logic             cdb_valid,
   input  logic             cdb_ready,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [31:0]      cdb_data
);

   localparam int W = 2 + 32 + 32 + TAG_W;

   logic [W-1:0]     head;
   logic             full;
   logic             empty;
   logic             push;
   logic             dispatch;
   logic [1:0]       head_op;
   logic [31:0]      head_a;
   logic [31:0]      head_b;
   logic [TAG_W-1:0] head_tag;

   logic [0:0]       state;
   logic             killed;
   logic [1:0]       fl_op;
   logic [TAG_W-1:0] fl_tag;

   assign {head_op, head_a, head_b, head_tag} = head;

   assign req_ready = !full;
   assign push      = req_valid && !full && !flush;
   // The result reg must be free (or freeing this cycle) before a new multiply may start.
   assign dispatch  = (state == S_IDLE) && !empty && mul_idle
                      && (!cdb_valid || cdb_ready) && !flush;

   assign mul_in_en    = dispatch;
   assign mul_a        = empty ? '0 : head_a;
   assign mul_b        = empty ? '0 : head_b;
   assign mul_a_signed = !empty && op_a_signed(head_op);
   assign mul_b_signed = !empty && op_b_signed(head_op);

   mul_req_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .push  (push),
      .pop   (dispatch),
      .wdata ({req_op, req_rs1, req_rs2, req_tag}),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         killed    <= 1'b0;
         fl_op     <= '0;
         fl_tag    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
      end else begin
         if (flush || (cdb_valid && cdb_ready)) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
         end
         if (state == S_IDLE) begin
            if (dispatch) begin
               state  <= S_WAIT;
               fl_op  <= head_op;
               fl_tag <= head_tag;
            end
         end else begin
            if (mul_out_en) begin
               state  <= S_IDLE;
               killed <= 1'b0;
               // A flush landing on the completion cycle discards the result directly.
               if (!killed && !flush) begin
                  cdb_valid <= 1'b1;
                  cdb_tag   <= fl_tag;
                  cdb_data  <= (fl_op == OP_MUL) ? mul_lo : mul_hi;
               end
            end else if (flush) begin
               killed <= 1'b1;
            end
         end
      end
   end

endmodule
